// File: rtl/fetch_stage_pkg.sv
// Shared constants and state encoding for the instruction-fetch stage.
// FETCH_PREFETCH_EN selects the 2-deep prefetch buffer instead of the 1-entry hold register.
package fetch_stage_pkg;

  localparam logic [31:0] NOP_INSTR_WORD = 32'h00000013;
  localparam int unsigned PC_INC = 4;

  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t ST_FETCH = 2'd0;
  localparam fetch_state_t ST_WAIT  = 2'd1;
  localparam fetch_state_t ST_HOLD  = 2'd2;

`ifdef FETCH_PREFETCH_EN
  localparam int FETCH_DEPTH = 2;
`else
  localparam int FETCH_DEPTH = 1;
`endif

endpackage

// File: rtl/fetch_buffer.sv
// Response buffer for the fetch stage: hold register (DEPTH=1) or small FIFO (DEPTH=2).
// Shift-style storage; flush empties it, push and pop may happen in the same cycle.
module fetch_buffer
  import fetch_stage_pkg::*;
#(
  parameter int DEPTH = 1,
  parameter int W     = 42
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [1:0]   cnt_q, cnt_d;

  always_comb begin
    mem_d = mem_q;
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = 2'd0;
    end else begin
      if (pop && cnt_q != 2'd0) begin
        for (int i = 0; i < DEPTH - 1; i++) mem_d[i] = mem_q[i+1];
        cnt_d = cnt_q - 2'd1;
      end
      // Write lands behind whatever survives the pop.
      if (push && int'(cnt_d) < DEPTH) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (i == int'(cnt_d)) mem_d[i] = wdata;
        end
        cnt_d = cnt_d + 2'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= 2'd0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end

  assign head  = mem_q[0];
  assign count = cnt_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ready + rvalid interface, redirects on branch.
// FETCH_PREFETCH_EN: two outstanding requests and a 2-entry response FIFO; otherwise single outstanding.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int                 PC_SIZE   = 10,
  parameter logic [PC_SIZE-1:0] RESET_PC  = '0,
  parameter logic [31:0]        NOP_INSTR = NOP_INSTR_WORD
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               id_stall,
  input  logic               branch_taken,
  input  logic [PC_SIZE-1:0] branch_target,
  output logic               imem_req,
  output logic [PC_SIZE-1:0] imem_addr,
  input  logic               imem_ready,
  input  logic               imem_rvalid,
  input  logic [31:0]        imem_rdata,
  output logic [PC_SIZE-1:0] PC_out,
  output logic [31:0]        instruction,
  output logic               if_valid,
  output logic [1:0]         dbg_state
);

  // Handshake: a request is accepted on any cycle with imem_req && imem_ready; each accepted request
  // returns exactly one imem_rvalid beat, in order, at least one cycle later. Decode takes the output
  // on any cycle with if_valid && !id_stall.
  localparam int BW = 32 + PC_SIZE;

  logic [PC_SIZE-1:0] pc_q, pc_d;
  logic [1:0]         osd_q, osd_d;
  logic [1:0]         disc_q, disc_d;
  logic [PC_SIZE-1:0] out_pc_q, out_pc_d;
  logic [31:0]        out_instr_q, out_instr_d;
  logic               out_valid_q, out_valid_d;

  logic [1:0]         buf_count;
  logic [BW-1:0]      buf_head, buf_wdata;
  logic               buf_push, buf_pop;
  logic               accept, rv_live, rv_drop, slot_free, load_out;
  logic [PC_SIZE-1:0] rsp_pc;
  logic [1:0]         inflight;

  // Credit: live outstanding requests plus buffered words never exceed the buffer depth.
  assign imem_req  = reset && (disc_q == 2'd0) &&
                     (({1'b0, osd_q} + {1'b0, buf_count}) < 3'(FETCH_DEPTH));
  assign imem_addr = pc_q;
  assign accept    = imem_req && imem_ready;
  assign rv_live   = imem_rvalid && (disc_q == 2'd0) && (osd_q != 2'd0);
  assign rv_drop   = imem_rvalid && (disc_q != 2'd0);

  // Live requests were issued back to back from the current redirect, so the oldest sits osd_q words back.
  assign rsp_pc    = pc_q - PC_SIZE'(PC_INC * osd_q);
  assign slot_free = !out_valid_q || !id_stall;
  assign load_out  = slot_free && (buf_count != 2'd0 || rv_live);
  assign buf_wdata = {imem_rdata, rsp_pc};
  assign buf_push  = !branch_taken && rv_live && !(load_out && buf_count == 2'd0);
  assign buf_pop   = !branch_taken && load_out && (buf_count != 2'd0);

  fetch_buffer #(
    .DEPTH (FETCH_DEPTH),
    .W     (BW)
  ) u_fetch_buffer (
    .clock (clock),
    .reset (reset),
    .flush (branch_taken),
    .push  (buf_push),
    .pop   (buf_pop),
    .wdata (buf_wdata),
    .head  (buf_head),
    .count (buf_count)
  );

  always_comb begin
    pc_d        = pc_q;
    osd_d       = osd_q;
    disc_d      = disc_q;
    out_pc_d    = out_pc_q;
    out_instr_d = out_instr_q;
    out_valid_d = out_valid_q;
    inflight    = disc_q + osd_q + {1'b0, accept};
    if (branch_taken) begin
      // Everything in flight becomes garbage; a beat arriving now retires one of them immediately.
      if (imem_rvalid && (disc_q != 2'd0 || osd_q != 2'd0)) inflight = inflight - 2'd1;
      pc_d        = branch_target;
      osd_d       = 2'd0;
      disc_d      = inflight;
      out_valid_d = 1'b0;
      out_instr_d = NOP_INSTR;
    end else begin
      if (accept) pc_d = pc_q + PC_SIZE'(PC_INC);
      osd_d  = osd_q + {1'b0, accept} - {1'b0, rv_live};
      disc_d = disc_q - {1'b0, rv_drop};
      if (load_out) begin
        out_valid_d = 1'b1;
        if (buf_count != 2'd0) begin
          {out_instr_d, out_pc_d} = buf_head;
        end else begin
          out_instr_d = imem_rdata;
          out_pc_d    = rsp_pc;
        end
      end else if (slot_free) begin
        out_valid_d = 1'b0;
        out_instr_d = NOP_INSTR;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q        <= RESET_PC;
      osd_q       <= 2'd0;
      disc_q      <= 2'd0;
      out_pc_q    <= RESET_PC;
      out_instr_q <= NOP_INSTR;
      out_valid_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      osd_q       <= osd_d;
      disc_q      <= disc_d;
      out_pc_q    <= out_pc_d;
      out_instr_q <= out_instr_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    if (buf_count != 2'd0)                    dbg_state = ST_HOLD;
    else if (osd_q != 2'd0 || disc_q != 2'd0) dbg_state = ST_WAIT;
    else                                      dbg_state = ST_FETCH;
  end

  assign PC_out      = out_pc_q;
  assign instruction = out_instr_q;
  assign if_valid    = out_valid_q;

endmodule
